memoria_dados_io: RTL
=====================

MEMORIA_DADOS_IO -- requirements
Module: memoria_dados_io

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clock and reset, with reset asserted at reset=0.
REQ-002 SHALL have port clock, input, 1 bit: rising-edge system clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-004 SHALL have port enderecoDado, input, 8 bits: data address from the CPU.
REQ-005 SHALL have port dadoEscr, input, 8 bits: write data from the CPU.
REQ-006 SHALL have port MemWrite, input, 1 bit: write strobe, sampled at the rising edge.
REQ-007 SHALL have port MemLoad, input, 1 bit: read enable.
REQ-008 SHALL have port dadoLido, output, 8 bits: read data to the CPU.
REQ-009 SHALL have port porta_entrada, input, 8 bits: asynchronous external input port.
REQ-010 SHALL have port porta_saida, output, 8 bits: registered external output port.
REQ-011 SHALL have port timer_irq, output, 1 bit: timer-expired flag.

Function
REQ-012 SHALL use this address map:
- 0x00-0xEF: RAM, 240x8.
- 0xF0: SAIDA, R/W.
- 0xF1: ENTRADA, R.
- 0xF2: CICLOS, R.
- 0xF3: TCTRL, R/W.
- 0xF4: TRELOAD, R/W.
- 0xF5: TSTATUS, R/W1C.
- 0xF6: TCOUNT, R.
- 0xF7-0xFF: reserved.
REQ-013 SHALL drive dadoLido combinationally in the same cycle, with no wait states: the selected location's value when MemLoad=1, otherwise 0x00.
REQ-014 SHALL perform writes at the rising edge when MemWrite=1.
REQ-015 SHALL ignore writes to read-only or reserved addresses; reserved reads SHALL return 0x00.
REQ-016 SHALL, when MemLoad=1 and MemWrite=1 to the same address in one cycle, return the pre-edge value, with the write taking effect at the edge.
REQ-017 SHALL drive porta_saida directly from register SAIDA.
REQ-018 SHALL pass porta_entrada through a 2-flop synchronizer; an ENTRADA read SHALL return the second stage, giving a 2-cycle latency.
REQ-019 SHALL increment CICLOS by 1 every cycle, wrapping 0xFF->0x00.
REQ-020 SHALL define TCTRL bits as: bit0 EN, bit1 AUTO; bits 7:2 SHALL be ignored on write and read as 0.
REQ-021 SHALL, on a write to TCTRL with bit0=1, load TCOUNT<=TRELOAD at that edge (no decrement that cycle) and set EN.
REQ-022 SHALL, on a write to TCTRL with bit0=0, clear EN and freeze TCOUNT.
REQ-023 SHALL, when EN=1 and TCOUNT!=0 and TCTRL is not written that cycle, decrement TCOUNT by 1.
REQ-024 SHALL, when EN=1 and TCOUNT==0, set the expired flag; then TCOUNT<=TRELOAD if AUTO=1, else EN<=0 and TCOUNT stays 0.
REQ-025 SHALL give a period of TRELOAD+1 cycles per expiry in auto mode; TRELOAD=0 SHALL set the flag every cycle.
REQ-026 SHALL read TSTATUS as: bit0 expired flag, bit1 EN, other bits 0.
REQ-027 SHALL clear the flag on a TSTATUS write with bit0=1; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-028 SHALL drive timer_irq equal to the expired flag, registered.
REQ-029 SHALL not change TCOUNT or the flag on a TRELOAD write; the new value SHALL apply at the next load or reload.

Reset
REQ-030 SHALL, on reset=0, immediately reset SAIDA, TCTRL, TRELOAD, TCOUNT, CICLOS, the flag and both synchronizer stages to 0x00/0; this drives porta_saida=0x00 and timer_irq=0.
REQ-031 SHALL leave RAM contents unaffected by reset.
REQ-032 SHALL, on reset assertion mid-count, abort the count; after release the timer SHALL stay idle until TCTRL is written.
REQ-033 SHALL apply no register updates on the first edge where reset=0 is held.

Verification
REQ-034 SHALL cover: write 0x5A to 0x10, then MemLoad at 0x10 -> dadoLido=0x5A in the same cycle; MemLoad=0 -> dadoLido=0x00.
REQ-035 SHALL cover: write 0xC3 to 0xF0 -> porta_saida=0xC3 after the edge; a read of 0xF0 returns 0xC3; a write to 0xF2 is ignored.
REQ-036 SHALL cover: porta_entrada changes to 0x81 -> ENTRADA reads the old value for 1 edge and 0x81 after 2 edges.
REQ-037 SHALL cover: TRELOAD=3, TCTRL=0x03 -> timer_irq rises after 4 cycles; clearing the flag via TSTATUS=0x01 and waiting -> timer_irq rises again 4 cycles after the previous expiry.
REQ-038 SHALL cover: TRELOAD=2, TCTRL=0x01 -> the flag sets once, TSTATUS reads 0x01 (EN=0), and TCOUNT stays 0x00.
REQ-039 SHALL cover: reset pulsed low mid-count with SAIDA=0xC3 -> porta_saida=0x00 and timer_irq=0 asynchronously, while RAM[0x10] still reads 0x5A.

Source files
------------

// File: rtl/memoria_dados_io.sv
`default_nettype none
// ============================================================================
// Module      : memoria_dados_io
// Description : CPU data memory with memory-mapped I/O. 240-byte RAM,
//               a registered output port, a synchronized input port, a free
//               running cycle counter and a down-counting timer with an
//               expiry flag.
// Ports       : clock         - rising-edge system clock
//               reset         - asynchronous reset, active low
//               enderecoDado  - data address (8 bits)
//               dadoEscr      - write data (8 bits)
//               MemWrite      - write strobe, taken at the rising edge
//               MemLoad       - read enable; dadoLido is 0x00 when low
//               dadoLido      - combinational read data (8 bits)
//               porta_entrada - asynchronous external input (8 bits)
//               porta_saida   - external output, driven from SAIDA
//               timer_irq     - timer expired flag
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_dados_io (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] enderecoDado,
  input  logic [7:0] dadoEscr,
  input  logic       MemWrite,
  input  logic       MemLoad,
  output logic [7:0] dadoLido,
  input  logic [7:0] porta_entrada,
  output logic [7:0] porta_saida,
  output logic       timer_irq
);

  localparam logic [7:0] c_addrSaida    = 8'hF0;
  localparam logic [7:0] c_addrEntrada  = 8'hF1;
  localparam logic [7:0] c_addrCiclos   = 8'hF2;
  localparam logic [7:0] c_addrTCtrl    = 8'hF3;
  localparam logic [7:0] c_addrTReload  = 8'hF4;
  localparam logic [7:0] c_addrTStatus  = 8'hF5;
  localparam logic [7:0] c_addrTCount   = 8'hF6;
  localparam logic [7:0] c_ramTop       = 8'hF0;  // first address above RAM

  logic [7:0] r_ram [0:239];
  logic [7:0] r_saida;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_ciclos;
  logic       r_tEn;
  logic       r_tAuto;
  logic [7:0] r_tReload;
  logic [7:0] r_tCount;
  logic       r_tFlag;

  logic w_ramSel;
  logic w_wrRam;
  logic w_wrSaida;
  logic w_wrTCtrl;
  logic w_wrTReload;
  logic w_wrTStatus;
  logic w_expire;

  assign w_ramSel    = (enderecoDado < c_ramTop);
  assign w_wrRam     = MemWrite && w_ramSel;
  assign w_wrSaida   = MemWrite && (enderecoDado == c_addrSaida);
  assign w_wrTCtrl   = MemWrite && (enderecoDado == c_addrTCtrl);
  assign w_wrTReload = MemWrite && (enderecoDado == c_addrTReload);
  assign w_wrTStatus = MemWrite && (enderecoDado == c_addrTStatus);

  // A TCTRL write owns the timer for that edge, so an expiry is not
  // evaluated in the same cycle as a (re)start or stop.
  assign w_expire = r_tEn && !w_wrTCtrl && (r_tCount == 8'h00);

  // RAM keeps its contents through reset, but writes are blocked while
  // reset is held so no state changes on a reset-asserted edge.
  always_ff @(posedge clock) begin
    if (reset && w_wrRam) begin
      r_ram[enderecoDado] <= dadoEscr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_saida  <= 8'h00;
      r_sync1  <= 8'h00;
      r_sync2  <= 8'h00;
      r_ciclos <= 8'h00;
    end else begin
      r_sync1  <= porta_entrada;
      r_sync2  <= r_sync1;
      r_ciclos <= r_ciclos + 8'h01;
      if (w_wrSaida) begin
        r_saida <= dadoEscr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tEn     <= 1'b0;
      r_tAuto   <= 1'b0;
      r_tReload <= 8'h00;
      r_tCount  <= 8'h00;
      r_tFlag   <= 1'b0;
    end else begin
      if (w_wrTReload) begin
        r_tReload <= dadoEscr;
      end

      if (w_wrTCtrl) begin
        r_tEn   <= dadoEscr[0];
        r_tAuto <= dadoEscr[1];
        // Starting loads the reload value; stopping freezes the count.
        if (dadoEscr[0]) begin
          r_tCount <= r_tReload;
        end
      end else if (r_tEn) begin
        if (r_tCount != 8'h00) begin
          r_tCount <= r_tCount - 8'h01;
        end else if (r_tAuto) begin
          r_tCount <= r_tReload;
        end else begin
          r_tEn <= 1'b0;
        end
      end

      // Set has priority over a simultaneous write-one-to-clear.
      if (w_expire) begin
        r_tFlag <= 1'b1;
      end else if (w_wrTStatus && dadoEscr[0]) begin
        r_tFlag <= 1'b0;
      end
    end
  end

  // Reads see pre-edge state, so a same-cycle write shows up only afterwards.
  always_comb begin
    dadoLido = 8'h00;
    if (MemLoad) begin
      case (enderecoDado)
        c_addrSaida:   dadoLido = r_saida;
        c_addrEntrada: dadoLido = r_sync2;
        c_addrCiclos:  dadoLido = r_ciclos;
        c_addrTCtrl:   dadoLido = {6'b000000, r_tAuto, r_tEn};
        c_addrTReload: dadoLido = r_tReload;
        c_addrTStatus: dadoLido = {6'b000000, r_tEn, r_tFlag};
        c_addrTCount:  dadoLido = r_tCount;
        default: begin
          if (w_ramSel) begin
            dadoLido = r_ram[enderecoDado];
          end
        end
      endcase
    end
  end

  assign porta_saida = r_saida;
  assign timer_irq   = r_tFlag;

endmodule
`default_nettype wire
